// File: rtl/midi_voice_allocator.sv
// MIDI byte parser and note-on/off voice allocator: running-status parsing into
// per-voice note/velocity/gate registers, with retrigger, free-voice and round-robin steal.

module midi_voice_lane (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic       vel_we_i,
  input  logic       clr_i,
  input  logic [6:0] note_i,
  input  logic [6:0] vel_i,
  output logic [6:0] note_o,
  output logic [6:0] vel_o,
  output logic       gate_o
);

  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;

  always_comb begin
    note_d = note_q;
    vel_d  = vel_q;
    gate_d = gate_q;
    if (load_i) begin
      note_d = note_i;
      vel_d  = vel_i;
      gate_d = 1'b1;
    end else begin
      if (vel_we_i) vel_d  = vel_i;
      if (clr_i)    gate_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      note_q <= '0;
      vel_q  <= '0;
      gate_q <= 1'b0;
    end else begin
      note_q <= note_d;
      vel_q  <= vel_d;
      gate_q <= gate_d;
    end
  end

  assign note_o = note_q;
  assign vel_o  = vel_q;
  assign gate_o = gate_q;

endmodule

module midi_voice_allocator #(
  parameter int NUMVOICES = 4,
  parameter int CHANNEL   = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    midi_byte,
  input  logic                          midi_valid,
  output logic [NUMVOICES-1:0][6:0]     midi_notenums,
  output logic [NUMVOICES-1:0][6:0]     voice_velocity,
  output logic [NUMVOICES-1:0]          voice_gates,
  output logic                          voice_update
);

  localparam int PW = (NUMVOICES > 1) ? $clog2(NUMVOICES) : 1;
  localparam logic [3:0] CH = CHANNEL[3:0];

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WNOTE = 2'd1;
  localparam logic [1:0] S_WVEL  = 2'd2;
  localparam logic [1:0] S_IGN   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          rs_on_q, rs_on_d;
  logic [6:0]    note_q, note_d;
  logic [PW-1:0] steal_q, steal_d;
  logic          upd_q, upd_d;
  logic          ev;

  // Byte parser: realtime bytes fall through untouched so they can sit mid-message.
  always_comb begin
    state_d = state_q;
    rs_on_d = rs_on_q;
    note_d  = note_q;
    ev      = 1'b0;
    if (midi_valid) begin
      if (midi_byte[7]) begin
        if (midi_byte[7:3] == 5'b11111) begin
          state_d = state_q;
        end else if (midi_byte[7:4] == 4'hF) begin
          state_d = S_IDLE;
          rs_on_d = 1'b0;
        end else if (midi_byte[7:4] == 4'h8 && midi_byte[3:0] == CH) begin
          state_d = S_WNOTE;
          rs_on_d = 1'b0;
        end else if (midi_byte[7:4] == 4'h9 && midi_byte[3:0] == CH) begin
          state_d = S_WNOTE;
          rs_on_d = 1'b1;
        end else begin
          state_d = S_IGN;
        end
      end else begin
        case (state_q)
          S_WNOTE: begin
            note_d  = midi_byte[6:0];
            state_d = S_WVEL;
          end
          S_WVEL: begin
            ev      = 1'b1;
            state_d = S_WNOTE;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  logic                 ev_on, ev_off;
  logic [NUMVOICES-1:0] match, free;
  logic [PW-1:0]        hit_idx, free_idx;
  logic [NUMVOICES-1:0] load, vel_we, clr;

  assign ev_on  = ev && rs_on_q && (midi_byte[6:0] != 7'd0);
  assign ev_off = ev && !ev_on;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUMVOICES; i++)
      match[i] = voice_gates[i] && (midi_notenums[i] == note_q);
    free = ~voice_gates;
  end

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NUMVOICES-1; i >= 0; i--) begin
      if (match[i]) hit_idx  = PW'(i);
      if (free[i])  free_idx = PW'(i);
    end
  end

  always_comb begin
    load    = '0;
    vel_we  = '0;
    clr     = '0;
    steal_d = steal_q;
    upd_d   = 1'b0;
    if (ev_on) begin
      upd_d = 1'b1;
      if (|match) begin
        vel_we[hit_idx] = 1'b1;
      end else if (|free) begin
        load[free_idx] = 1'b1;
      end else begin
        load[steal_q] = 1'b1;
        steal_d = (steal_q == PW'(NUMVOICES-1)) ? '0 : steal_q + 1'b1;
      end
    end else if (ev_off) begin
      clr   = match;
      upd_d = |match;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rs_on_q <= 1'b0;
      note_q  <= '0;
      steal_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_on_q <= rs_on_d;
      note_q  <= note_d;
      steal_q <= steal_d;
      upd_q   <= upd_d;
    end
  end

  for (genvar g = 0; g < NUMVOICES; g++) begin : g_lane
    midi_voice_lane u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (load[g]),
      .vel_we_i (vel_we[g]),
      .clr_i    (clr[g]),
      .note_i   (note_q),
      .vel_i    (midi_byte[6:0]),
      .note_o   (midi_notenums[g]),
      .vel_o    (voice_velocity[g]),
      .gate_o   (voice_gates[g])
    );
  end

  assign voice_update = upd_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench for midi_voice_allocator: stimulus queues hand-computed voice states,
// a negedge monitor pops and compares one entry per voice_update pulse.

module tb_midi_voice_allocator;

  typedef struct packed {
    logic [3:0][6:0] n;
    logic [3:0][6:0] v;
    logic [3:0]      g;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [7:0]      midi_byte = 8'h00;
  logic            midi_valid = 1'b0;
  logic [3:0][6:0] notes, vels;
  logic [3:0]      gates;
  logic            upd;

  int    checks = 0;
  int    errors = 0;
  exp_t  q[$];
  string nq[$];

  midi_voice_allocator #(.NUMVOICES(4), .CHANNEL(0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .midi_byte      (midi_byte),
    .midi_valid     (midi_valid),
    .midi_notenums  (notes),
    .voice_velocity (vels),
    .voice_gates    (gates),
    .voice_update   (upd)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [6:0] n0, n1, n2, n3,
                              input logic [6:0] v0, v1, v2, v3,
                              input logic [3:0] g);
    exp_t r;
    r.n[0] = n0; r.n[1] = n1; r.n[2] = n2; r.n[3] = n3;
    r.v[0] = v0; r.v[1] = v1; r.v[2] = v2; r.v[3] = v3;
    r.g = g;
    return r;
  endfunction

  task automatic cmp(input string nm, input exp_t e);
    checks++;
    if (notes !== e.n) begin
      errors++;
      $display("FAIL %s notes got %h want %h", nm, notes, e.n);
    end
    checks++;
    if (vels !== e.v) begin
      errors++;
      $display("FAIL %s vels got %h want %h", nm, vels, e.v);
    end
    checks++;
    if (gates !== e.g) begin
      errors++;
      $display("FAIL %s gates got %b want %b", nm, gates, e.g);
    end
  endtask

  // Monitor: every update pulse must correspond to exactly one queued expectation.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (reset_n === 1'b1 && upd === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update gates=%b notes=%h", gates, notes);
      end else begin
        e  = q.pop_front();
        nm = nq.pop_front();
        cmp(nm, e);
      end
    end
  end

  task automatic expv(input string nm, input exp_t e);
    q.push_back(e);
    nq.push_back(nm);
  endtask

  // Entered and left on a negedge, so consecutive calls give back-to-back strobes.
  task automatic send(input logic [7:0] b);
    midi_byte  = b;
    midi_valid = 1'b1;
    @(negedge clk);
    midi_valid = 1'b0;
  endtask

  task automatic check_done(input string nm);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_updates got %0d want 0", nm, q.size());
      q.delete();
      nq.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    cmp("reset", '0);
    q.delete();
    nq.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    #1;
    do_reset();

    // T1: basic note-on
    expv("t1_on", mk(7'h3C,0,0,0, 7'h64,0,0,0, 4'b0001));
    send(8'h90); send(8'h3C); send(8'h64);
    check_done("t1");

    // T2: running status fill, steal rotation, retrigger, note-off via vel 0
    do_reset();
    send(8'h90);
    expv("t2_v0", mk(7'h3C,0,0,0, 7'h64,0,0,0, 4'b0001));
    send(8'h3C); send(8'h64);
    expv("t2_v1", mk(7'h3C,7'h40,0,0, 7'h64,7'h50,0,0, 4'b0011));
    send(8'h40); send(8'h50);
    expv("t2_v2", mk(7'h3C,7'h40,7'h43,0, 7'h64,7'h50,7'h7F,0, 4'b0111));
    send(8'h43); send(8'h7F);
    expv("t2_v3", mk(7'h3C,7'h40,7'h43,7'h48, 7'h64,7'h50,7'h7F,7'h20, 4'b1111));
    send(8'h48); send(8'h20);
    expv("t2_steal0", mk(7'h4A,7'h40,7'h43,7'h48, 7'h10,7'h50,7'h7F,7'h20, 4'b1111));
    send(8'h4A); send(8'h10);
    expv("t2_steal1", mk(7'h4A,7'h4C,7'h43,7'h48, 7'h10,7'h11,7'h7F,7'h20, 4'b1111));
    send(8'h4C); send(8'h11);
    expv("t2_steal2", mk(7'h4A,7'h4C,7'h4E,7'h48, 7'h10,7'h11,7'h12,7'h20, 4'b1111));
    send(8'h4E); send(8'h12);
    expv("t2_steal3", mk(7'h4A,7'h4C,7'h4E,7'h50, 7'h10,7'h11,7'h12,7'h13, 4'b1111));
    send(8'h50); send(8'h13);
    expv("t2_wrap", mk(7'h52,7'h4C,7'h4E,7'h50, 7'h14,7'h11,7'h12,7'h13, 4'b1111));
    send(8'h52); send(8'h14);
    expv("t2_retrig", mk(7'h52,7'h4C,7'h4E,7'h50, 7'h14,7'h33,7'h12,7'h13, 4'b1111));
    send(8'h4C); send(8'h33);
    expv("t2_ptr_hold", mk(7'h52,7'h54,7'h4E,7'h50, 7'h14,7'h15,7'h12,7'h13, 4'b1111));
    send(8'h54); send(8'h15);
    expv("t2_vel0_off", mk(7'h52,7'h54,7'h4E,7'h50, 7'h14,7'h15,7'h12,7'h13, 4'b1011));
    send(8'h4E); send(8'h00);
    expv("t2_refill", mk(7'h52,7'h54,7'h56,7'h50, 7'h14,7'h15,7'h16,7'h13, 4'b1111));
    send(8'h56); send(8'h16);
    check_done("t2");

    // T3: note-off holds pitch; unmatched note-off is silent
    do_reset();
    expv("t3_on", mk(7'h3C,0,0,0, 7'h64,0,0,0, 4'b0001));
    send(8'h90); send(8'h3C); send(8'h64);
    expv("t3_off", mk(7'h3C,0,0,0, 7'h64,0,0,0, 4'b0000));
    send(8'h3C); send(8'h00);
    send(8'h80); send(8'h3C); send(8'h40);
    check_done("t3");
    cmp("t3_nomatch_hold", mk(7'h3C,0,0,0, 7'h64,0,0,0, 4'b0000));

    // T4: realtime mid-message, wrong channel ignored, then real note-off
    do_reset();
    expv("t4_rt", mk(7'h3C,0,0,0, 7'h64,0,0,0, 4'b0001));
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    send(8'h91); send(8'h3C); send(8'h64); send(8'h40); send(8'h50);
    check_done("t4_wrongch");
    cmp("t4_wrongch_hold", mk(7'h3C,0,0,0, 7'h64,0,0,0, 4'b0001));
    expv("t4_off", mk(7'h3C,0,0,0, 7'h64,0,0,0, 4'b0000));
    send(8'h80); send(8'h3C); send(8'h00);
    check_done("t4");

    // T5: retrigger, system abort, status abort in WAIT_VEL
    do_reset();
    expv("t5_on", mk(7'h3C,0,0,0, 7'h64,0,0,0, 4'b0001));
    send(8'h90); send(8'h3C); send(8'h64);
    expv("t5_retrig", mk(7'h3C,0,0,0, 7'h7F,0,0,0, 4'b0001));
    send(8'h90); send(8'h3C); send(8'h7F);
    send(8'h90); send(8'h3C); send(8'hF0); send(8'h64);
    check_done("t5_sys");
    cmp("t5_sys_hold", mk(7'h3C,0,0,0, 7'h7F,0,0,0, 4'b0001));
    expv("t5_abort", mk(7'h3C,7'h46,0,0, 7'h7F,7'h50,0,0, 4'b0011));
    send(8'h90); send(8'h45); send(8'h90); send(8'h46); send(8'h50);
    check_done("t5");

    // T6: reset between note and velocity bytes
    do_reset();
    expv("t6_on", mk(7'h3C,0,0,0, 7'h64,0,0,0, 4'b0001));
    send(8'h90); send(8'h3C); send(8'h64);
    check_done("t6_pre");
    send(8'h90); send(8'h40);
    reset_n = 1'b0;
    #1;
    cmp("t6_async_reset", '0);
    @(negedge clk);
    reset_n = 1'b1;
    send(8'h64); send(8'h3C); send(8'h64);
    check_done("t6_post");
    cmp("t6_dropped", '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
